// File: rtl/rv32_types.sv
// ---------------------------------------------------------------------------
// rv32_types
// Shared types and constants for the RV32 decode-stage hazard logic.
//   reg_id_t         : architectural register index (x0..x31)
//   REG_ZERO         : x0, hard-wired zero, never a hazard source
//   NO_BYPASS        : bypass_sel encoding meaning "read the register file"
//   *_DEFAULT        : default sizing used by the hazard unit parameters
// ---------------------------------------------------------------------------
package rv32_types;

    localparam int NUM_RS_DEFAULT  = 3;
    localparam int NUM_FWD_DEFAULT = 2;
    localparam int MAX_OUT_DEFAULT = 4;

    // bypass_sel value k+1 means "forward from stage k"; 0 is the register file.
    localparam int NO_BYPASS = 0;

    typedef logic [4:0] reg_id_t;

    localparam reg_id_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rv32_scoreboard.sv
// ---------------------------------------------------------------------------
// rv32_scoreboard
// 32-entry pending-write scoreboard plus in-flight counter for the
// variable-latency unit.
//   clk, rst     : clock, asynchronous active-high reset
//   set_en/set_rd: mark set_rd pending (long-latency issue accepted)
//   clr_en/clr_rd: write-back of clr_rd; ignored unless clr_rd is pending
//   busy_vec     : bit r set = register r has a write in flight (bit 0 is 0)
//   outstanding  : number of in-flight long-latency writes
// ---------------------------------------------------------------------------
module rv32_scoreboard
    import rv32_types::*;
#(
    parameter  int MAX_OUT = MAX_OUT_DEFAULT,
    localparam int OW      = $clog2(MAX_OUT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  reg_id_t       set_rd,
    input  logic          clr_en,
    input  reg_id_t       clr_rd,
    output logic [31:0]   busy_vec,
    output logic [OW-1:0] outstanding
);

    logic [31:0]   busy_q, busy_d;
    logic [OW-1:0] out_q, out_d;
    logic          set_eff, clr_eff;

    // NOTE: every combinational output is given a default before any
    // conditional update, so no path leaves it unassigned and no latch forms.
    always_comb begin
        set_eff = set_en && (set_rd != REG_ZERO);
        // A write-back only counts if the register really is pending; stray
        // or post-reset completions must not disturb the counter.
        clr_eff = clr_en && (clr_rd != REG_ZERO) && busy_q[clr_rd];

        busy_d = busy_q;
        if (clr_eff) busy_d[clr_rd] = 1'b0;
        // Set is applied last so it wins over a same-register clear.
        if (set_eff) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;

        out_d = out_q;
        if (set_eff && !clr_eff) begin
            out_d = out_q + OW'(1);
        end else if (!set_eff && clr_eff) begin
            out_d = out_q - OW'(1);
        end
    end

    // NOTE: the busy array is reset like any other state register: a reset
    // must drop every pending entry, so leaving it uninitialised is not an
    // option here even though it looks like a small memory.
    // NOTE: sequential state is updated with non-blocking assignments only,
    // so all flops sample their next-state values from the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
            out_q  <= '0;
        end else begin
            busy_q <= busy_d;
            out_q  <= out_d;
        end
    end

    assign busy_vec    = busy_q;
    assign outstanding = out_q;

endmodule

// File: rtl/rv32_scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// rv32_scoreboard_hazard_unit
// Decode-stage hazard detection for an RV32 pipeline: operand bypass
// selection, data / structural / WAW stall generation, long-latency
// scoreboard and a saturating stall-cycle counter.
//   clk, rst          : clock, asynchronous active-high reset
//   use_rs, rs_id     : per-slot source operand enable and register
//   issue_*           : decoded instruction (valid, writes rd, rd, long op)
//   flush             : kill the instruction in decode
//   fwd_wb/rd/ok      : forwarding stages, index 0 youngest
//   done_valid/rd     : variable-latency unit write-back
//   stall             : combinational decode hold
//   bypass_sel        : per slot, 0 = register file, k+1 = stage k
//   busy_vec          : scoreboard bits
//   outstanding       : in-flight long ops
//   stall_cycles      : saturating count of stalled cycles
// ---------------------------------------------------------------------------
module rv32_scoreboard_hazard_unit
    import rv32_types::*;
#(
    parameter  int NUM_RS  = NUM_RS_DEFAULT,
    parameter  int NUM_FWD = NUM_FWD_DEFAULT,
    parameter  int MAX_OUT = MAX_OUT_DEFAULT,
    localparam int SW      = $clog2(NUM_FWD + 1),
    localparam int OW      = $clog2(MAX_OUT + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RS-1:0]          use_rs,
    input  reg_id_t [NUM_RS-1:0]       rs_id,
    input  logic                       issue_valid,
    input  logic                       issue_wb,
    input  reg_id_t                    issue_rd,
    input  logic                       issue_long,
    input  logic                       flush,
    input  logic [NUM_FWD-1:0]         fwd_wb,
    input  reg_id_t [NUM_FWD-1:0]      fwd_rd,
    input  logic [NUM_FWD-1:0]         fwd_ok,
    input  logic                       done_valid,
    input  reg_id_t                    done_rd,
    output logic                       stall,
    output logic [NUM_RS-1:0][SW-1:0]  bypass_sel,
    output logic [31:0]                busy_vec,
    output logic [OW-1:0]              outstanding,
    output logic [31:0]                stall_cycles
);

    logic        data_stall, struct_stall, waw_stall;
    logic        accept;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    always_comb begin : operand_check
        logic [SW-1:0] sel;
        logic          sel_ok;
        data_stall = 1'b0;
        bypass_sel = '0;
        for (int s = 0; s < NUM_RS; s++) begin
            sel    = SW'(NO_BYPASS);
            sel_ok = 1'b1;
            if (use_rs[s] && (rs_id[s] != REG_ZERO)) begin
                // Scan oldest to youngest so the youngest match overwrites.
                for (int k = NUM_FWD - 1; k >= 0; k--) begin
                    if (fwd_wb[k] && (fwd_rd[k] == rs_id[s])) begin
                        sel    = SW'(k + 1);
                        sel_ok = fwd_ok[k];
                    end
                end
                // Uses the registered busy bit: a same-cycle write-back has
                // not reached the register file yet, so the stall holds.
                if (!sel_ok || busy_vec[rs_id[s]]) data_stall = 1'b1;
            end
            bypass_sel[s] = sel;
        end
    end

    assign struct_stall = issue_long && (outstanding == OW'(MAX_OUT));
    assign waw_stall    = issue_wb && (issue_rd != REG_ZERO) && busy_vec[issue_rd];

    assign stall  = issue_valid && !flush && (data_stall || struct_stall || waw_stall);
    assign accept = issue_valid && !flush && !stall;

    rv32_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .set_en      (accept && issue_long),
        .set_rd      (issue_rd),
        .clr_en      (done_valid),
        .clr_rd      (done_rd),
        .busy_vec    (busy_vec),
        .outstanding (outstanding)
    );

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_cycles_q <= '0;
        else     stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_rv32_scoreboard_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_rv32_scoreboard_hazard_unit
// Directed bench for the hazard unit. Each cycle the stimulus pushes the
// values it expects onto a queue; at the falling edge the queue is drained
// and compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_rv32_scoreboard_hazard_unit;
    import rv32_types::*;

    localparam int NUM_RS  = 3;
    localparam int NUM_FWD = 2;
    localparam int MAX_OUT = 4;
    localparam int SW      = 2;
    localparam int OW      = 3;

    logic                      clk;
    logic                      rst;
    logic [NUM_RS-1:0]         use_rs;
    reg_id_t [NUM_RS-1:0]      rs_id;
    logic                      issue_valid, issue_wb, issue_long, flush;
    reg_id_t                   issue_rd;
    logic [NUM_FWD-1:0]        fwd_wb, fwd_ok;
    reg_id_t [NUM_FWD-1:0]     fwd_rd;
    logic                      done_valid;
    reg_id_t                   done_rd;
    logic                      stall;
    logic [NUM_RS-1:0][SW-1:0] bypass_sel;
    logic [31:0]               busy_vec;
    logic [OW-1:0]             outstanding;
    logic [31:0]               stall_cycles;

    rv32_scoreboard_hazard_unit #(
        .NUM_RS  (NUM_RS),
        .NUM_FWD (NUM_FWD),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .use_rs       (use_rs),
        .rs_id        (rs_id),
        .issue_valid  (issue_valid),
        .issue_wb     (issue_wb),
        .issue_rd     (issue_rd),
        .issue_long   (issue_long),
        .flush        (flush),
        .fwd_wb       (fwd_wb),
        .fwd_rd       (fwd_rd),
        .fwd_ok       (fwd_ok),
        .done_valid   (done_valid),
        .done_rd      (done_rd),
        .stall        (stall),
        .bypass_sel   (bypass_sel),
        .busy_vec     (busy_vec),
        .outstanding  (outstanding),
        .stall_cycles (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {SIG_STALL, SIG_BYP0, SIG_BYP1, SIG_BYP2, SIG_BUSY, SIG_OUT, SIG_CYC} sig_e;
    typedef struct {
        string       tag;
        sig_e        sig;
        logic [31:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   model_stalls = 0;   // bench's own count of stalled, clocked cycles

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SIG_STALL: return {31'd0, stall};
            SIG_BYP0:  return {30'd0, bypass_sel[0]};
            SIG_BYP1:  return {30'd0, bypass_sel[1]};
            SIG_BYP2:  return {30'd0, bypass_sel[2]};
            SIG_BUSY:  return busy_vec;
            SIG_OUT:   return {29'd0, outstanding};
            default:   return stall_cycles;
        endcase
    endfunction

    task automatic expect_sig(input string tag, input sig_e s, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.exp = v;
        exp_q.push_back(e);
    endtask

    // Stall expectation for a cycle that will be clocked out of reset.
    task automatic expect_stall(input string tag, input bit v);
        expect_sig(tag, SIG_STALL, {31'd0, v});
        if (v) model_stalls++;
    endtask

    task automatic expect_state(input string tag, input logic [31:0] busy, input int outs);
        expect_sig({tag, "_busy"}, SIG_BUSY, busy);
        expect_sig({tag, "_out"}, SIG_OUT, 32'(outs));
        expect_sig({tag, "_cyc"}, SIG_CYC, 32'(model_stalls));
    endtask

    task automatic drain();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sig), e.exp);
        end
    endtask

    task automatic idle();
        use_rs      = '0;
        rs_id       = '0;
        issue_valid = 1'b0;
        issue_wb    = 1'b0;
        issue_rd    = '0;
        issue_long  = 1'b0;
        flush       = 1'b0;
        fwd_wb      = '0;
        fwd_rd      = '0;
        fwd_ok      = '0;
        done_valid  = 1'b0;
        done_rd     = '0;
    endtask

    task automatic issue_long_op(input reg_id_t rd);
        issue_valid = 1'b1;
        issue_wb    = 1'b1;
        issue_long  = 1'b1;
        issue_rd    = rd;
    endtask

    // Compare at the falling edge, then advance past the next rising edge.
    task automatic step();
        @(negedge clk);
        drain();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst = 1'b1;
        // Hazard logic stays live during reset, using cleared state.
        issue_valid = 1'b1;
        use_rs[0] = 1'b1;  rs_id[0] = 5'd5;
        fwd_wb[0] = 1'b1;  fwd_rd[0] = 5'd5;  fwd_ok[0] = 1'b0;
        expect_state("rst", 32'h0, 0);
        expect_sig("rst_stall", SIG_STALL, 32'd1);
        expect_sig("rst_byp0", SIG_BYP0, 32'd1);
        step();
        rst = 1'b0;

        // Both stages match: youngest wins.
        idle();
        issue_valid = 1'b1;
        use_rs[0] = 1'b1;  rs_id[0] = 5'd5;
        fwd_wb = 2'b11;  fwd_rd[0] = 5'd5;  fwd_rd[1] = 5'd5;  fwd_ok = 2'b11;
        expect_sig("young_byp0", SIG_BYP0, 32'd1);
        expect_stall("young_stall", 1'b0);
        step();

        // Load-use: load in exec stalls, then forwards from mem.
        idle();
        issue_valid = 1'b1;
        use_rs[1] = 1'b1;  rs_id[1] = 5'd7;
        fwd_wb[0] = 1'b1;  fwd_rd[0] = 5'd7;  fwd_ok[0] = 1'b0;
        expect_sig("load_byp1", SIG_BYP1, 32'd1);
        expect_stall("load_stall", 1'b1);
        step();
        fwd_wb = 2'b10;  fwd_rd[1] = 5'd7;  fwd_ok = 2'b10;
        expect_sig("load_mem_byp1", SIG_BYP1, 32'd2);
        expect_state("load_mem", 32'h0, 0);
        expect_stall("load_mem_stall", 1'b0);
        step();

        // Long op to x9, dependent read stalls through the done cycle.
        idle();
        issue_long_op(5'd9);
        expect_stall("long9_issue", 1'b0);
        step();
        idle();
        issue_valid = 1'b1;
        use_rs[0] = 1'b1;  rs_id[0] = 5'd9;
        expect_state("long9_busy", 32'h0000_0200, 1);
        expect_stall("raw9_stall", 1'b1);
        step();
        idle();
        issue_valid = 1'b1;
        issue_wb = 1'b1;  issue_rd = 5'd9;
        expect_stall("waw9_stall", 1'b1);
        step();
        idle();
        issue_valid = 1'b1;
        use_rs[0] = 1'b1;  rs_id[0] = 5'd9;
        done_valid = 1'b1;  done_rd = 5'd9;
        expect_stall("raw9_done_stall", 1'b1);
        step();
        done_valid = 1'b0;
        expect_state("raw9_after", 32'h0, 0);
        expect_stall("raw9_after_stall", 1'b0);
        step();

        // Fill the long-op unit, then hit the structural limit.
        for (int i = 1; i <= 4; i++) begin
            idle();
            issue_long_op(reg_id_t'(i));
            expect_stall($sformatf("fill%0d", i), 1'b0);
            step();
        end
        idle();
        issue_long_op(5'd5);
        expect_state("full", 32'h0000_001E, 4);
        expect_stall("full_stall", 1'b1);
        step();
        // At the limit the count is the registered one, so the issue still
        // stalls while the write-back of x2 retires.
        idle();
        issue_long_op(5'd6);
        done_valid = 1'b1;  done_rd = 5'd2;
        expect_stall("full_done2_stall", 1'b1);
        step();
        // Below the limit: accept and retire in one cycle, count unchanged.
        done_rd = 5'd3;
        expect_state("done2", 32'h0000_001A, 3);
        expect_stall("x6_issue_stall", 1'b0);
        step();
        idle();
        expect_state("x6_in", 32'h0000_0052, 3);
        step();
        done_valid = 1'b1;  done_rd = 5'd1;
        step();
        done_rd = 5'd4;
        step();
        done_rd = 5'd6;
        step();
        // Stray write-back of a non-busy register must not underflow.
        done_rd = 5'd6;
        expect_state("drained", 32'h0, 0);
        step();
        idle();
        expect_state("stray_done", 32'h0, 0);
        step();

        // x0 never hazards; inactive slots never hazard; flush issues nothing.
        idle();
        issue_valid = 1'b1;
        use_rs[0] = 1'b1;  rs_id[0] = 5'd0;
        use_rs[2] = 1'b0;  rs_id[2] = 5'd12;
        fwd_wb = 2'b11;  fwd_rd[0] = 5'd0;  fwd_rd[1] = 5'd12;  fwd_ok = 2'b00;
        expect_sig("x0_byp0", SIG_BYP0, 32'd0);
        expect_sig("inact_byp2", SIG_BYP2, 32'd0);
        expect_stall("x0_stall", 1'b0);
        step();
        idle();
        issue_long_op(5'd3);
        flush = 1'b1;
        expect_stall("flush_stall", 1'b0);
        step();
        idle();
        expect_state("flush_after", 32'h0, 0);
        step();

        // Asynchronous reset with x9 pending, then a stale write-back.
        issue_long_op(5'd9);
        step();
        idle();
        expect_state("pre_rst", 32'h0000_0200, 1);
        @(negedge clk);
        drain();
        #2;
        rst = 1'b1;
        #1;
        model_stalls = 0;
        expect_state("async_rst", 32'h0, 0);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        done_valid = 1'b1;  done_rd = 5'd9;
        step();
        idle();
        expect_state("post_rst_done", 32'h0, 0);
        expect_stall("post_rst_stall", 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
